// File: rtl/quad_decoder.sv
// quad_decoder: synchronized, glitch-filtered Gray quadrature decoder driving a wrapping position counter.
// Define QUAD_INDEX_EN to add the enc_z index input, whose filtered rising edge zeroes the count.
module quad_filter #(
  parameter int W = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] pin,
  output logic [W-1:0] filt,
  output logic         ld
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_CYCLES - 1);
  logic [W-1:0] s1, s2, cand;
  logic [FW-1:0] fcnt;
  logic hit;
  assign hit = (s2 == cand) && (fcnt == FMAX);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      fcnt <= '0;
      filt <= '0;
      ld   <= 1'b0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      cand <= s2;
      fcnt <= (s2 != cand) ? '0 : (fcnt == FMAX) ? fcnt : fcnt + FW'(1);
      if (hit) filt <= cand;
      ld   <= hit;
    end
endmodule

module quad_decoder #(
  parameter int COUNT_BITS = 16,
  parameter int FILTER_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enc_a,
  input  logic                  enc_b,
`ifdef QUAD_INDEX_EN
  input  logic                  enc_z,
`endif
  input  logic                  clear,
  input  logic                  err_clr,
  output logic [COUNT_BITS-1:0] count,
  output logic                  step,
  output logic                  dir,
  output logic                  err
);
  logic [1:0] filt, prev, dp;
  logic ld, primed, up, dn, bad, zero;
  quad_filter #(.W(2), .FILTER_CYCLES(FILTER_CYCLES)) u_ab (
    .clk(clk), .resetn(resetn), .pin({enc_a, enc_b}), .filt(filt), .ld(ld)
  );
  // {b, a^b} numbers the up sequence 00,10,11,01 as 0..3; the mod-4 delta classifies the move
  assign dp  = {filt[0], ^filt} - {prev[0], ^prev};
  assign up  = primed && dp == 2'd1;
  assign dn  = primed && dp == 2'd3;
  assign bad = primed && dp == 2'd2;
`ifdef QUAD_INDEX_EN
  logic zf, zld, zprev, zprimed;
  quad_filter #(.W(1), .FILTER_CYCLES(FILTER_CYCLES)) u_z (
    .clk(clk), .resetn(resetn), .pin(enc_z), .filt(zf), .ld(zld)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      zprimed <= 1'b0;
      zprev   <= 1'b0;
    end else begin
      zprimed <= zprimed | zld;
      if (zprimed | zld) zprev <= zf;
    end
  assign zero = clear | (zprimed & zf & ~zprev);
`else
  assign zero = clear;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      primed <= 1'b0;
      prev   <= '0;
      count  <= '0;
      step   <= 1'b0;
      dir    <= 1'b0;
      err    <= 1'b0;
    end else begin
      primed <= primed | ld;
      if (primed | ld) prev <= filt;
      step   <= up | dn;
      if (up | dn) dir <= up;
      count  <= zero ? '0 : up ? count + COUNT_BITS'(1) : dn ? count - COUNT_BITS'(1) : count;
      err    <= bad | (err & ~err_clr);
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed tables and hand sequences plus random pins against a window-based reference model.
module tb_quad_decoder;
  localparam int F = 4;
  typedef struct {
    logic [1:0]  ab;
    int          hold;
    logic        clr;
    logic [15:0] cnt;
    logic        dir;
    logic        err;
  } vec_t;
  logic clk = 0, resetn = 0, enc_a = 0, enc_b = 0, clear = 0, err_clr = 0;
`ifdef QUAD_INDEX_EN
  logic enc_z = 0;
`endif
  logic [15:0] c4, c16;
  logic s4, s16, d4, dr16, e4, e16;
  int checks = 0, errors = 0, ecnt = 0;
  bit chk_en = 0;
  logic [1:0] upseq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;
  quad_decoder #(.COUNT_BITS(16), .FILTER_CYCLES(F)) dut (
    .clk(clk), .resetn(resetn), .enc_a(enc_a), .enc_b(enc_b),
`ifdef QUAD_INDEX_EN
    .enc_z(enc_z),
`endif
    .clear(clear), .err_clr(err_clr), .count(c4), .step(s4), .dir(d4), .err(e4)
  );
  quad_decoder #(.COUNT_BITS(16), .FILTER_CYCLES(16)) d16 (
    .clk(clk), .resetn(resetn), .enc_a(enc_a), .enc_b(enc_b),
`ifdef QUAD_INDEX_EN
    .enc_z(enc_z),
`endif
    .clear(clear), .err_clr(err_clr), .count(c16), .step(s16), .dir(dr16), .err(e16)
  );
  // reference model for the F=4 instance: a pin level is accepted once its synchronized copy
  // (the level two edges earlier) has been seen on F+1 consecutive edges; the move is judged
  // from positions along the up cycle and takes effect on the following edge
  int pos [4] = '{0, 3, 1, 2};
  logic [1:0] hq [$];
  logic [1:0] m_acc;
  bit m_has, m_zpend;
  int m_pend;
  logic [15:0] m_count;
  logic m_step, m_dir, m_err;
`ifdef QUAD_INDEX_EN
  logic [1:0] zq [$];
  logic m_zacc;
  bit m_zhas;
`endif
  function automatic bit settled(input logic [1:0] q [$], input int n, output logic [1:0] v);
    v = (n >= 3) ? q[n-3] : 2'b00;
    if (n < F) return 1'b0;
    for (int k = n - F; k < n; k++)
      if (((k >= 3) ? q[k-3] : 2'b00) != v) return 1'b0;
    return 1'b1;
  endfunction
  always @(posedge clk or negedge resetn) begin
    logic [1:0] v;
    int d;
    if (!resetn) begin
      hq.delete();
      m_has = 0; m_acc = 0; m_pend = 0; m_zpend = 0;
      m_count = 0; m_step = 0; m_dir = 0; m_err = 0;
`ifdef QUAD_INDEX_EN
      zq.delete();
      m_zhas = 0; m_zacc = 0;
`endif
    end else begin
      m_step = m_pend == 1 || m_pend == 2;
      if (m_step) m_dir = m_pend == 1;
      m_count = (clear || m_zpend) ? 16'd0 : m_pend == 1 ? m_count + 16'd1 :
                m_pend == 2 ? m_count - 16'd1 : m_count;
      m_err = m_pend == 3 || (m_err && !err_clr);
      hq.push_back({enc_a, enc_b});
      m_pend = 0;
      if (settled(hq, hq.size(), v)) begin
        if (m_has) begin
          d = (pos[v] - pos[m_acc]) & 3;
          m_pend = d == 1 ? 1 : d == 3 ? 2 : d == 2 ? 3 : 0;
        end
        m_has = 1;
        m_acc = v;
      end
      m_zpend = 0;
`ifdef QUAD_INDEX_EN
      zq.push_back({1'b0, enc_z});
      if (settled(zq, zq.size(), v)) begin
        m_zpend = m_zhas && !m_zacc && v[0];
        m_zhas = 1;
        m_zacc = v[0];
      end
`endif
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, ecnt);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_count", c4, m_count);
        chk("model_step", s4, m_step);
        chk("model_dir", d4, m_dir);
        chk("model_err", e4, m_err);
      end
    end
  endtask
  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    #2 resetn = 0;
    {enc_a, enc_b} = ab;
    clear = 0;
    err_clr = 0;
`ifdef QUAD_INDEX_EN
    enc_z = 0;
`endif
    cyc(2);
    resetn = 1;
  endtask
  initial begin
    vec_t tv [9];
    int seen, np, lat, e0;
    tv[0] = '{2'b10, 10, 1'b0, 16'd1,      1'b1, 1'b0};
    tv[1] = '{2'b11, 10, 1'b0, 16'd2,      1'b1, 1'b0};
    tv[2] = '{2'b01, 10, 1'b0, 16'd3,      1'b1, 1'b0};
    tv[3] = '{2'b00, 10, 1'b0, 16'd4,      1'b1, 1'b0};
    tv[4] = '{2'b01, 10, 1'b0, 16'd3,      1'b0, 1'b0};
    tv[5] = '{2'b00, 10, 1'b1, 16'd0,      1'b1, 1'b0};
    tv[6] = '{2'b01, 10, 1'b0, 16'hFFFF,   1'b0, 1'b0};
    tv[7] = '{2'b00, 10, 1'b0, 16'd0,      1'b1, 1'b0};
    tv[8] = '{2'b11, 10, 1'b0, 16'd0,      1'b1, 1'b1};
    // reset held with both pins high: values at release, then a silent prime
    do_reset(2'b11);
    chk_en = 1;
    chk("rst_count", c4, 0);
    chk("rst_step", s4, 0);
    chk("rst_dir", d4, 0);
    chk("rst_err", e4, 0);
    seen = 0;
    repeat (12) begin cyc(1); seen += int'(s4); end
    chk("prime_steps", seen, 0);
    chk("prime_count", c4, 0);
    chk("prime_err", e4, 0);
    // FILTER_CYCLES=16 latency: each accepted edge appears 19 edges after the pin change
    do_reset(2'b00);
    cyc(25);
    for (int i = 0; i < 4; i++) begin
      {enc_a, enc_b} = upseq[i];
      e0 = ecnt + 1;
      np = 0;
      lat = -1;
      repeat (20) begin
        cyc(1);
        if (s16) begin np++; lat = ecnt - e0; end
      end
      chk("lat16", lat, 19);
      chk("pulses16", np, 1);
    end
    chk("count16", c16, 4);
    chk("dir16", dr16, 1);
    chk("count4", c4, 4);
    // table of steps, wrap, clear and an illegal jump
    do_reset(2'b00);
    cyc(12);
    for (int i = 0; i < 9; i++) begin
      {enc_a, enc_b} = tv[i].ab;
      clear = tv[i].clr;
      cyc(tv[i].hold);
      clear = 0;
      chk($sformatf("tv%0d_count", i), c4, tv[i].cnt);
      chk($sformatf("tv%0d_dir", i), d4, tv[i].dir);
      chk($sformatf("tv%0d_err", i), e4, tv[i].err);
    end
    err_clr = 1;
    cyc(1);
    err_clr = 0;
    chk("err_clr_alone", e4, 0);
    {enc_a, enc_b} = 2'b01;
    cyc(3);
    {enc_a, enc_b} = 2'b11;
    seen = 0;
    repeat (12) begin cyc(1); seen += int'(s4); end
    chk("glitch_steps", seen, 0);
    chk("glitch_count", c4, 0);
    chk("glitch_err", e4, 0);
    // illegal 11->00 decoded on edge 7 after the change, with err_clr on that same edge
    {enc_a, enc_b} = 2'b00;
    cyc(7);
    err_clr = 1;
    cyc(1);
    err_clr = 0;
    chk("err_set_wins", e4, 1);
    chk("err_count", c4, 0);
    // clear coinciding with a decoded up edge at count 7
    do_reset(2'b00);
    cyc(10);
    for (int i = 0; i < 7; i++) begin {enc_a, enc_b} = upseq[i % 4]; cyc(8); end
    chk("pre_clear", c4, 7);
    {enc_a, enc_b} = 2'b00;
    cyc(7);
    clear = 1;
    cyc(1);
    clear = 0;
    chk("clr_count", c4, 0);
    chk("clr_step", s4, 1);
    chk("clr_dir", d4, 1);
`ifdef QUAD_INDEX_EN
    do_reset(2'b00);
    cyc(10);
    for (int i = 0; i < 42; i++) begin {enc_a, enc_b} = upseq[i % 4]; cyc(8); end
    chk("idx_pre", c4, 42);
    enc_z = 1;
    cyc(10);
    chk("idx_rise", c4, 0);
    {enc_a, enc_b} = upseq[2];
    cyc(10);
    chk("idx_high", c4, 1);
    enc_z = 0;
    cyc(10);
    chk("idx_fall", c4, 1);
`endif
    // random pins, clears and occasional mid-run resets against the model
    do_reset(2'b00);
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset(2'($urandom));
      {enc_a, enc_b} = 2'($urandom);
`ifdef QUAD_INDEX_EN
      if ($urandom_range(0, 3) == 0) enc_z = ~enc_z;
`endif
      repeat ($urandom_range(1, 10)) begin
        clear = $urandom_range(0, 19) == 0;
        err_clr = $urandom_range(0, 15) == 0;
        cyc(1);
      end
    end
    clear = 0;
    err_clr = 0;
    cyc(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
